// File: rtl/line_xfer_ctrl.sv
// Miss sequencer for one arbiter channel: optional dirty writeback, then line read and fill.
// Optional watchdog / response-tag filter enabled by defining LINE_XFER_TIMEOUT_EN.
module line_xfer_ctrl #(
  parameter int                       BUS_DATA_WIDTH = 64,
  parameter int                       BUS_TAG_WIDTH  = 13,
  parameter logic [BUS_TAG_WIDTH-2:0] TAG_ID         = 12'h000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        miss_valid,
  output logic                        miss_ready,
  input  logic [BUS_DATA_WIDTH-1:0]   fill_addr,
  input  logic                        wb_valid,
  input  logic [BUS_DATA_WIDTH-1:0]   wb_addr,
  input  logic [8*BUS_DATA_WIDTH-1:0] wb_data,
  output logic                        fill_done,
  output logic [8*BUS_DATA_WIDTH-1:0] fill_data,
  output logic                        reqcyc,
  input  logic                        reqack,
  output logic [BUS_DATA_WIDTH-1:0]   req,
  output logic [BUS_TAG_WIDTH-1:0]    reqtag,
  input  logic                        respcyc,
  output logic                        respack,
  input  logic [BUS_DATA_WIDTH-1:0]   resp,
  input  logic [BUS_TAG_WIDTH-1:0]    resptag,
  output logic                        xfer_err
);

  localparam int LINE_W = 8 * BUS_DATA_WIDTH;
  localparam int OFF_W  = 6;

  typedef enum logic [2:0] {IDLE, WB_ADDR, WB_DATA, RD_ADDR, RD_DATA, DONE} state_t;

  state_t                    state, state_nxt;
  logic [2:0]                cnt;
  logic [BUS_DATA_WIDTH-1:0] fill_addr_q, wb_addr_q;
  logic [LINE_W-1:0]         wb_buf, fill_buf;
  logic                      accept, beat_done, resp_take, tag_ok, timeout, op;

  assign accept    = miss_valid && (state == IDLE);
  assign beat_done = reqcyc && reqack;
  assign resp_take = (state == RD_DATA) && respcyc && tag_ok;
  assign fill_data = fill_buf;

`ifdef LINE_XFER_TIMEOUT_EN
  logic [15:0] wdog;
  logic        active;
  logic        unused_bits;

  assign active      = (state == WB_ADDR) || (state == WB_DATA) ||
                       (state == RD_ADDR) || (state == RD_DATA);
  assign tag_ok      = (resptag[BUS_TAG_WIDTH-2:0] == TAG_ID);
  assign timeout     = active && (wdog == '1);
  assign xfer_err    = timeout;
  assign unused_bits = ^{resptag[BUS_TAG_WIDTH-1], fill_addr[OFF_W-1:0], wb_addr[OFF_W-1:0]};

  // Mismatched-tag beats are still acked, so they count as bus progress.
  always_ff @(posedge clk) begin
    if (reset || !active || beat_done || respack) wdog <= '0;
    else                                          wdog <= wdog + 16'd1;
  end
`else
  logic unused_bits;

  assign tag_ok      = 1'b1;
  assign timeout     = 1'b0;
  assign xfer_err    = 1'b0;
  assign unused_bits = ^{resptag, fill_addr[OFF_W-1:0], wb_addr[OFF_W-1:0]};
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = wb_valid ? WB_ADDR : RD_ADDR;
      WB_ADDR: if (beat_done) state_nxt = WB_DATA;
      WB_DATA: if (beat_done && cnt == 3'd7) state_nxt = RD_ADDR;
      RD_ADDR: if (beat_done) state_nxt = RD_DATA;
      RD_DATA: if (resp_take && cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  always_comb begin
    miss_ready = (state == IDLE);
    fill_done  = (state == DONE);
    reqcyc     = 1'b0;
    respack    = 1'b0;
    req        = '0;
    op         = 1'b0;
    case (state)
      WB_ADDR: begin reqcyc = 1'b1; op = 1'b1; req = wb_addr_q; end
      WB_DATA: begin reqcyc = 1'b1; op = 1'b1; req = wb_buf[BUS_DATA_WIDTH*cnt +: BUS_DATA_WIDTH]; end
      RD_ADDR: begin reqcyc = 1'b1; req = fill_addr_q; end
      RD_DATA: respack = respcyc;
      default: ;
    endcase
    reqtag = reqcyc ? {op, TAG_ID} : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      fill_addr_q <= '0;
      wb_addr_q   <= '0;
      wb_buf      <= '0;
      fill_buf    <= '0;
    end else begin
      if (accept) begin
        fill_addr_q <= {fill_addr[BUS_DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        wb_addr_q   <= {wb_addr[BUS_DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        wb_buf      <= wb_data;
        cnt         <= '0;
      end
      // Address beats restart the counter; data beats advance it and wrap 7->0.
      if (beat_done) begin
        if (state == WB_DATA) cnt <= cnt + 3'd1;
        else                  cnt <= '0;
      end
      if (resp_take) begin
        fill_buf[BUS_DATA_WIDTH*cnt +: BUS_DATA_WIDTH] <= resp;
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_line_xfer_ctrl.sv
// Self-checking bench for line_xfer_ctrl: directed scenarios plus randomized misses
// checked against a transaction-level model of expected bus beats and fill line.
module tb_line_xfer_ctrl;

  localparam logic [11:0] TAG = 12'h000;

  logic         clk = 1'b0;
  logic         reset, miss_valid, wb_valid, reqack, respcyc;
  logic [63:0]  fill_addr, wb_addr, resp;
  logic [511:0] wb_data;
  logic [12:0]  resptag;
  logic         miss_ready, fill_done, reqcyc, respack, xfer_err;
  logic [511:0] fill_data;
  logic [63:0]  req;
  logic [12:0]  reqtag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  line_xfer_ctrl #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .TAG_ID(TAG)) dut (
    .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_ready(miss_ready),
    .fill_addr(fill_addr), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .fill_done(fill_done), .fill_data(fill_data), .reqcyc(reqcyc), .reqack(reqack),
    .req(req), .reqtag(reqtag), .respcyc(respcyc), .respack(respack), .resp(resp),
    .resptag(resptag), .xfer_err(xfer_err)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int unsigned i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [511:0] seq_line(input logic [63:0] base);
    logic [511:0] l;
    for (int unsigned i = 0; i < 8; i++) l[64*i +: 64] = base + 64'(i);
    return l;
  endfunction

  // One miss end to end. ack_mode 0: zero-wait except delay_n stalls on request beat
  // delay_idx; 1: random. resp_mode 0: always, 1: alternating, 2: random.
  // abort_idx >= 0 asserts reset while that request beat is presented.
  task automatic run_miss(input logic [63:0] f_addr, input logic wbv, input logic [63:0] w_addr,
                          input logic [511:0] w_data, input logic [511:0] r_line,
                          input int ack_mode, input int delay_idx, input int delay_n,
                          input int resp_mode, input int abort_idx, input logic [63:0] hold_val,
                          output int done_cyc, output int hold_n);
    logic [64:0] exp_q[$];
    int nreq, popped, ridx, cyc, waited, guard;
    logic req_ph, resp_ph, tog, done;

    if (wbv) begin
      exp_q.push_back({1'b1, w_addr[63:6], 6'b0});
      for (int unsigned i = 0; i < 8; i++) exp_q.push_back({1'b1, w_data[64*i +: 64]});
    end
    exp_q.push_back({1'b0, f_addr[63:6], 6'b0});
    nreq = exp_q.size();
    done_cyc = -1; hold_n = 0; ridx = 0; waited = 0; tog = 1'b1; done = 1'b0;

    guard = 0;
    @(negedge clk);
    while (miss_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    chk("idle_before_miss", miss_ready, 1'b1);
    @(posedge clk); #1;
    miss_valid = 1'b1; fill_addr = f_addr; wb_valid = wbv; wb_addr = w_addr; wb_data = w_data;
    @(negedge clk);
    chk("miss_ready_accept", miss_ready, 1'b1);
    @(posedge clk); #1;
    miss_valid = 1'b0; fill_addr = {$urandom, $urandom}; wb_addr = {$urandom, $urandom};
    wb_valid = 1'($urandom_range(0, 1)); wb_data = rand_line();
    cyc = 1;

    while (!done && cyc < 400) begin
      popped  = nreq - exp_q.size();
      req_ph  = (exp_q.size() > 0);
      resp_ph = !req_ph && ridx < 8;
      if (ack_mode == 0) begin
        if (req_ph && popped == delay_idx && waited < delay_n) begin reqack = 1'b0; waited++; end
        else reqack = 1'b1;
      end else reqack = ($urandom_range(0, 3) != 0);
      case (resp_mode)
        0:       respcyc = 1'b1;
        1:       begin respcyc = resp_ph && tog; if (resp_ph) tog = ~tog; end
        default: respcyc = ($urandom_range(0, 2) != 0);
      endcase
      resp    = resp_ph ? r_line[64*ridx +: 64] : {$urandom, $urandom};
      resptag = {1'($urandom_range(0, 1)), TAG};

      @(negedge clk);
      chk("reqcyc", reqcyc, req_ph);
      chk("respack", respack, resp_ph && respcyc);
      chk("fill_done", fill_done, !req_ph && ridx == 8);
      chk("miss_ready_busy", miss_ready, 1'b0);
      chk("xfer_err", xfer_err, 1'b0);
      if (req_ph) begin
        chk("req", req, exp_q[0][63:0]);
        chk("reqtag", reqtag, {exp_q[0][64], TAG});
      end
      if (reqcyc === 1'b1 && req === hold_val) hold_n++;
      if (req_ph && popped == abort_idx) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; respcyc = 1'b1; reqack = 1'b1;
        @(negedge clk);
        chk("abort_reqcyc", reqcyc, 1'b0);
        chk("abort_miss_ready", miss_ready, 1'b1);
        chk("abort_respack", respack, 1'b0);
        chk("abort_fill_data", fill_data, 512'd0);
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          chk("abort_no_fill_done", fill_done, 1'b0);
          chk("abort_idle", reqcyc, 1'b0);
        end
        return;
      end
      if (!req_ph && ridx == 8) begin
        chk("fill_data", fill_data, r_line);
        done = 1'b1; done_cyc = cyc;
      end
      if (req_ph && reqack) void'(exp_q.pop_front());
      if (resp_ph && respcyc) ridx++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("fill_done_seen", done, 1'b1);
    respcyc = 1'b1; reqack = 1'b1;
    @(negedge clk);
    chk("miss_ready_after", miss_ready, 1'b1);
    chk("fill_done_single", fill_done, 1'b0);
    chk("fill_data_held", fill_data, r_line);
  endtask

  int dc, hn;
  logic [511:0] rl;

  initial begin
    reset = 1'b1; miss_valid = 1'b0; wb_valid = 1'b0; reqack = 1'b1; respcyc = 1'b1;
    fill_addr = '0; wb_addr = '0; wb_data = '0; resp = 64'hDEAD; resptag = {1'b0, TAG};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_miss_ready", miss_ready, 1'b1);
    chk("rst_reqcyc", reqcyc, 1'b0);
    chk("rst_respack", respack, 1'b0);
    chk("rst_fill_done", fill_done, 1'b0);
    chk("rst_fill_data", fill_data, 512'd0);
    chk("rst_req", req, 64'd0);
    chk("rst_reqtag", reqtag, 13'd0);
    chk("rst_xfer_err", xfer_err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Clean miss, zero-wait arbiter.
    rl = seq_line(64'hA0);
    run_miss(64'h1047, 1'b0, 64'h0, 512'd0, rl, 0, -1, 0, 0, -1, 64'h1040, dc, hn);
    chk("clean_latency", dc, 10);
    chk("clean_beat0", fill_data[63:0], 64'hA0);
    chk("clean_beat7", fill_data[511:448], 64'hA7);

    // Dirty miss: victim address, 8 data beats, then the read.
    run_miss(64'h1047, 1'b1, 64'h2000, seq_line(64'hB0), seq_line(64'hC0),
             0, -1, 0, 0, -1, 64'h2000, dc, hn);
    chk("dirty_latency", dc, 19);

    // Stall three cycles on writeback data beat 4 (request index 5).
    run_miss(64'h1047, 1'b1, 64'h2000, seq_line(64'hB0), seq_line(64'hD0),
             0, 5, 3, 0, -1, 64'hB4, dc, hn);
    chk("stall_hold_cycles", hn, 4);
    chk("stall_latency", dc, 22);

    // Alternating response valid.
    run_miss(64'h1047, 1'b0, 64'h0, 512'd0, seq_line(64'hE0), 0, -1, 0, 1, -1, 64'h1, dc, hn);
    chk("toggle_latency", dc, 17);

    // Reset while writeback data beat 3 is on the bus.
    run_miss(64'h1047, 1'b1, 64'h2000, seq_line(64'hB0), seq_line(64'hF0),
             0, -1, 0, 0, 4, 64'h1, dc, hn);
    chk("abort_no_done", dc, -1);

    for (int i = 0; i < 8; i++) begin
      run_miss({$urandom, $urandom}, 1'($urandom_range(0, 1)), {$urandom, $urandom},
               rand_line(), rand_line(), 1, -1, 0, 2, -1, 64'h1, dc, hn);
    end

`ifdef LINE_XFER_TIMEOUT_EN
    begin
      int n;
      logic seen;
      @(posedge clk); #1;
      miss_valid = 1'b1; fill_addr = 64'h3000; wb_valid = 1'b0; reqack = 1'b0; respcyc = 1'b0;
      @(posedge clk); #1;
      miss_valid = 1'b0;
      n = 1; seen = 1'b0;
      while (!seen && n < 70000) begin
        @(negedge clk);
        if (xfer_err === 1'b1) seen = 1'b1;
        else begin @(posedge clk); #1; n++; end
      end
      chk("timeout_seen", seen, 1'b1);
      chk("timeout_cycle", n, 65536);
      chk("timeout_no_fill_done", fill_done, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("timeout_idle", miss_ready, 1'b1);
      chk("timeout_err_pulse", xfer_err, 1'b0);
      chk("timeout_reqcyc", reqcyc, 1'b0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
